// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: bundles the two write-requester handshakes and the
// register-file write-port outputs of rf_wr_arbiter into one interface.
// master: the requester side (drives valid/reg/data, observes everything else).
// slave:  the arbiter (drives readies, the rf write port and initDone).
interface rf_wr_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    // Requester 0 (e.g. ALU writeback)
    logic              req0Valid;
    logic              req0Ready;
    logic [ADDR_W-1:0] req0Reg;
    logic [DATA_W-1:0] req0Data;

    // Requester 1 (e.g. load unit)
    logic              req1Valid;
    logic              req1Ready;
    logic [ADDR_W-1:0] req1Reg;
    logic [DATA_W-1:0] req1Data;

    // Register-file write port and init status
    logic [ADDR_W-1:0] rfWReg;
    logic [DATA_W-1:0] rfData;
    logic              rfRegWrite;
    logic              initDone;

    modport master (
        output req0Valid, req0Reg, req0Data,
        output req1Valid, req1Reg, req1Data,
        input  req0Ready, req1Ready,
        input  rfWReg, rfData, rfRegWrite, initDone
    );

    modport slave (
        input  req0Valid, req0Reg, req0Data,
        input  req1Valid, req1Reg, req1Data,
        output req0Ready, req1Ready,
        output rfWReg, rfData, rfRegWrite, initDone
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: owns the single write port of the 32 x 64-bit register file.
// After reset it clears every register (INIT), then arbitrates two
// valid/ready requesters round-robin (RUN). All rf-facing outputs are
// registered, so an accepted write reaches the rf one cycle after acceptance.
// Optional feature macro: RF_ARB_ZERO_DROP_EN -- when defined, accepted RUN
// writes to register 0 complete their handshake but are not issued, keeping
// register 0 hard-wired to zero.
module rf_wr_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic             clk,
    input  logic             reset,
    rf_wr_arbiter_if.slave   bus
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arbState_t;

    // One extra bit keeps the last-address compare free of wrap ambiguity.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS - 1);

    arbState_t         stateReg,      stateNext;
    logic [ADDR_W:0]   initCntReg,    initCntNext;
    logic              ptrReg,        ptrNext;
    logic              rfRegWriteReg, rfRegWriteNext;
    logic [ADDR_W-1:0] rfWRegReg,     rfWRegNext;
    logic [DATA_W-1:0] rfDataReg,     rfDataNext;
    logic              initDoneReg,   initDoneNext;

    // Requesters gathered into arrays so the grant logic is written once.
    logic              reqValid [2];
    logic [ADDR_W-1:0] reqReg   [2];
    logic [DATA_W-1:0] reqData  [2];
    logic [1:0]        grant;
    logic              arbEnable;
    logic              xfer;
    logic [ADDR_W-1:0] selReg;
    logic [DATA_W-1:0] selData;

    assign reqValid[0] = bus.req0Valid;
    assign reqValid[1] = bus.req1Valid;
    assign reqReg[0]   = bus.req0Reg;
    assign reqReg[1]   = bus.req1Reg;
    assign reqData[0]  = bus.req0Data;
    assign reqData[1]  = bus.req1Data;

    // Readies are only ever offered in RUN and never while reset is asserted.
    assign arbEnable = !reset && (stateReg == RUN);

    // A requester wins if it is valid and either alone or favoured by the pointer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = arbEnable && reqValid[gi] &&
                               (!reqValid[1-gi] || (ptrReg == 1'(gi)));
        end
    endgenerate

    assign bus.req0Ready = grant[0];
    assign bus.req1Ready = grant[1];

    // Ready implies valid, so any grant is a completed transfer this cycle.
    assign xfer    = |grant;
    assign selReg  = grant[1] ? reqReg[1]  : reqReg[0];
    assign selData = grant[1] ? reqData[1] : reqData[0];

    // Next-state and next-output logic for the INIT/RUN sequencer.
    always_comb begin
        stateNext      = stateReg;
        initCntNext    = initCntReg;
        ptrNext        = ptrReg;
        rfRegWriteNext = 1'b0;
        rfWRegNext     = rfWRegReg;
        rfDataNext     = rfDataReg;
        initDoneNext   = initDoneReg;

        case (stateReg)
            INIT: begin
                rfRegWriteNext = 1'b1;
                rfWRegNext     = initCntReg[ADDR_W-1:0];
                rfDataNext     = '0;
                initCntNext    = initCntReg + 1'b1;
                if (initCntReg == LAST_IDX) begin
                    stateNext    = RUN;
                    initDoneNext = 1'b1;
                end
            end

            RUN: begin
                if (xfer) begin
                    // Hand priority to the requester that just lost (or was idle).
                    ptrNext = grant[0];
`ifdef RF_ARB_ZERO_DROP_EN
                    if (selReg != '0) begin
                        rfRegWriteNext = 1'b1;
                        rfWRegNext     = selReg;
                        rfDataNext     = selData;
                    end
`else
                    rfRegWriteNext = 1'b1;
                    rfWRegNext     = selReg;
                    rfDataNext     = selData;
`endif
                end
            end

            default: begin
                stateNext = INIT;
            end
        endcase
    end

    // State and output registers; reset cancels any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg      <= INIT;
            initCntReg    <= '0;
            ptrReg        <= 1'b0;
            rfRegWriteReg <= 1'b0;
            rfWRegReg     <= '0;
            rfDataReg     <= '0;
            initDoneReg   <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            initCntReg    <= initCntNext;
            ptrReg        <= ptrNext;
            rfRegWriteReg <= rfRegWriteNext;
            rfWRegReg     <= rfWRegNext;
            rfDataReg     <= rfDataNext;
            initDoneReg   <= initDoneNext;
        end
    end

    assign bus.rfRegWrite = rfRegWriteReg;
    assign bus.rfWReg     = rfWRegReg;
    assign bus.rfData     = rfDataReg;
    assign bus.initDone   = initDoneReg;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed self-checking bench for rf_wr_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Honours RF_ARB_ZERO_DROP_EN for the register-0 write case.
module tb_rf_wr_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    rf_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                          input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1);
        bus.req0Valid = v0;
        bus.req0Reg   = r0;
        bus.req0Data  = d0;
        bus.req1Valid = v1;
        bus.req1Reg   = r1;
        bus.req1Data  = d1;
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [ADDR_W-1:0] r,
                              input logic [DATA_W-1:0] d);
        checkVal({tag, ".we"},   64'(bus.rfRegWrite), 64'(we));
        checkVal({tag, ".reg"},  64'(bus.rfWReg),     64'(r));
        checkVal({tag, ".data"}, bus.rfData,          d);
    endtask

    // Call right after reset drops, with requesters still asserting valid.
    task automatic checkInit(input string tag);
        for (int k = 0; k < NREGS; k++) begin
            edge1();
            checkWrite($sformatf("%s.clr%0d", tag, k), 1'b1, ADDR_W'(k), '0);
            checkVal($sformatf("%s.done%0d", tag, k), 64'(bus.initDone), 64'(k == NREGS - 1));
            checkVal($sformatf("%s.rdy0_%0d", tag, k), 64'(bus.req0Ready), 64'(0));
            checkVal($sformatf("%s.rdy1_%0d", tag, k), 64'(bus.req1Ready), 64'(0));
            if (k == NREGS - 2) setReq(0, 0, 0, 0, 0, 0);
        end
        edge1();
        checkWrite({tag, ".post"}, 1'b0, ADDR_W'(NREGS - 1), '0);
        checkVal({tag, ".doneHold"}, 64'(bus.initDone), 64'(1));
    endtask

    logic [ADDR_W-1:0] expReg  [8] = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};
    logic [DATA_W-1:0] expData [8] = '{64'd10, 64'd10, 64'd20, 64'd20, 64'd30, 64'd30, 64'd40, 64'd40};

    initial begin
        int q0;
        int q1;
        logic exp0;

        // Reset with both requesters pushing: readies must stay low.
        setReq(1, 5'd9, 64'hDEAD, 1, 5'd10, 64'hBEEF);
        reset = 1'b1;
        edge1();
        edge1();
        checkWrite("rst", 1'b0, '0, '0);
        checkVal("rst.done", 64'(bus.initDone),  64'(0));
        checkVal("rst.rdy0", 64'(bus.req0Ready), 64'(0));
        checkVal("rst.rdy1", 64'(bus.req1Ready), 64'(0));

        reset = 1'b0;
        checkInit("init");

        // Single req0 write, reg 3 data 30; pointer moves to 1.
        setReq(1, 5'd3, 64'd30, 0, 0, 0);
        #1;
        checkVal("single.rdy0", 64'(bus.req0Ready), 64'(1));
        checkVal("single.rdy1", 64'(bus.req1Ready), 64'(0));
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
        checkWrite("single.wr", 1'b1, 5'd3, 64'd30);
        edge1();
        checkWrite("single.idle", 1'b0, 5'd3, 64'd30);

        // req1 alone, reg 5 data 50; pointer moves back to 0.
        setReq(0, 0, 0, 1, 5'd5, 64'd50);
        #1;
        checkVal("r1only.rdy0", 64'(bus.req0Ready), 64'(0));
        checkVal("r1only.rdy1", 64'(bus.req1Ready), 64'(1));
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
        checkWrite("r1only.wr", 1'b1, 5'd5, 64'd50);

        // Both streaming: grants must alternate starting with req0.
        q0 = 0;
        q1 = 0;
        for (int i = 0; i < 8; i++) begin
            setReq(q0 < 4, ADDR_W'(1 + q0), DATA_W'((q0 + 1) * 10),
                   q1 < 4, ADDR_W'(17 + q1), DATA_W'((q1 + 1) * 10));
            #1;
            exp0 = (i % 2 == 0);
            checkVal($sformatf("rr%0d.rdy0", i), 64'(bus.req0Ready), 64'(exp0));
            checkVal($sformatf("rr%0d.rdy1", i), 64'(bus.req1Ready), 64'(!exp0));
            if (exp0) q0++; else q1++;
            edge1();
            checkWrite($sformatf("rr%0d.wr", i), 1'b1, expReg[i], expData[i]);
        end
        setReq(0, 0, 0, 0, 0, 0);
        edge1();
        checkVal("rr.idle.we", 64'(bus.rfRegWrite), 64'(0));

        // Reset mid-stream after 3 grants (0,1,0) leaves the pointer at 1 pre-reset.
        setReq(1, 5'd7, 64'hAA, 1, 5'd8, 64'hBB);
        for (int i = 0; i < 3; i++) begin
            edge1();
            checkWrite($sformatf("pre%0d", i), 1'b1, (i % 2 == 0) ? 5'd7 : 5'd8,
                       (i % 2 == 0) ? 64'hAA : 64'hBB);
        end
        reset = 1'b1;
        #1;
        checkVal("midrst.rdy0", 64'(bus.req0Ready), 64'(0));
        checkVal("midrst.rdy1", 64'(bus.req1Ready), 64'(0));
        edge1();
        checkWrite("midrst", 1'b0, '0, '0);
        checkVal("midrst.done", 64'(bus.initDone), 64'(0));
        reset = 1'b0;
        checkInit("reinit");
        for (int i = 0; i < 3; i++) begin
            edge1();
            checkVal($sformatf("nostale%0d.we", i), 64'(bus.rfRegWrite), 64'(0));
        end

        // Pointer must be back at 0 after reset: req0 wins a both-valid cycle.
        setReq(1, 5'd6, 64'd60, 1, 5'd9, 64'd90);
        #1;
        checkVal("ptrrst.rdy0", 64'(bus.req0Ready), 64'(1));
        checkVal("ptrrst.rdy1", 64'(bus.req1Ready), 64'(0));
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
        checkWrite("ptrrst.wr", 1'b1, 5'd6, 64'd60);

        // req1 now favoured; take one req1 write so req0 is favoured again.
        setReq(0, 0, 0, 1, 5'd9, 64'd90);
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
        checkWrite("r1b.wr", 1'b1, 5'd9, 64'd90);

        // Write to register 0.
        setReq(1, 5'd0, 64'd99, 0, 0, 0);
        #1;
        checkVal("zero.rdy0", 64'(bus.req0Ready), 64'(1));
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
`ifdef RF_ARB_ZERO_DROP_EN
        checkWrite("zero.drop", 1'b0, 5'd9, 64'd90);
`else
        checkWrite("zero.wr", 1'b1, 5'd0, 64'd99);
`endif
        // The register-0 handshake still rotated the pointer toward req1.
        setReq(1, 5'd2, 64'd1, 1, 5'd3, 64'd2);
        #1;
        checkVal("zero.ptr.rdy0", 64'(bus.req0Ready), 64'(0));
        checkVal("zero.ptr.rdy1", 64'(bus.req1Ready), 64'(1));
        edge1();
        setReq(0, 0, 0, 0, 0, 0);
        checkWrite("zero.ptr.wr", 1'b1, 5'd3, 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Sequences and shares the single write port of the 32 x 64-bit register file (rf) between two write requesters, e.g. the ALU writeback and the load unit.
- After reset, runs an init sequence that clears all 32 registers.
- Then grants the write port round-robin using valid/ready handshakes, with registered outputs driving rf's wReg/data/RegWrite inputs.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, register address width.
- NREGS, 32, number of registers cleared by the init sequence. Must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0Valid  input  1  requester 0 has a write pending.
- req0Ready  output  1  requester 0 write accepted this cycle.
- req0Reg  input  ADDR_W  requester 0 destination register.
- req0Data  input  DATA_W  requester 0 write data.
- req1Valid  input  1  requester 1 has a write pending.
- req1Ready  output  1  requester 1 write accepted this cycle.
- req1Reg  input  ADDR_W  requester 1 destination register.
- req1Data  input  DATA_W  requester 1 write data.
- rfWReg  output  ADDR_W  to rf wReg.
- rfData  output  DATA_W  to rf data.
- rfRegWrite  output  1  to rf RegWrite.
- initDone  output  1  high once the init clear sequence has completed.

Behaviour:
- Reset (reset high at a rising edge):
  - state=INIT, initCnt=0, priority pointer=0 (req0 favoured).
  - rfRegWrite=0, rfWReg=0, rfData=0, initDone=0.
  - req0Ready and req1Ready are combinationally forced low while reset is high.
- INIT state:
  - On each edge with reset low: rfRegWrite<=1, rfWReg<=initCnt, rfData<=0, initCnt<=initCnt+1.
  - On the edge that issues initCnt=NREGS-1: state<=RUN and initDone<=1.
  - Net effect: exactly NREGS consecutive write cycles, addresses 0..NREGS-1.
  - Both readies stay low throughout INIT.
- RUN state:
  - Readies are combinational from the current valids and the pointer:
    - Both valid: the requester named by the pointer gets ready=1.
    - One valid: that requester gets ready=1.
    - None valid: both readies are 0.
    - At most one ready is high in any cycle.
  - Transfer occurs when valid && ready at a rising edge.
  - Edge after a transfer: rfRegWrite<=1, rfWReg<=granted Reg, rfData<=granted Data. Write latency is 1 cycle from acceptance to rf input.
  - Edge with no transfer: rfRegWrite<=0; rfWReg and rfData hold their previous values.
  - Pointer update on any transfer: pointer<=other requester (toggles to the non-granted index). Unchanged when idle.
  - Sustained both-valid traffic alternates grants strictly: 0,1,0,1...
- Handshake rules:
  - A requester holds valid, Reg and Data stable until ready is seen.
  - The arbiter never drops an accepted request (unless the optional feature is enabled).
  - No internal buffering beyond the output register, so throughput is one write per cycle.
- Reset mid-operation:
  - Any in-flight output write is cancelled: rfRegWrite=0 on the reset edge.
  - Pointer returns to 0 and the block re-enters INIT, re-clearing the whole file.
  - No pre-reset request is ever emitted after reset.
- Width rules:
  - initCnt is ADDR_W+1 bits so the termination compare is unambiguous.
  - Reg inputs are used unmodified; no address range checks (all 2**ADDR_W addresses are valid).

Optional Feature:
- Macro RF_ARB_ZERO_DROP_EN.
- Defined: in RUN, an accepted request with Reg==0 completes its handshake and rotates the pointer, but rfRegWrite<=0 on the following edge. rfWReg and rfData hold, so register 0 stays zero. INIT still writes register 0.
- Undefined: writes to register 0 are issued like any other register.

Test Plan:
- Reset high 2 cycles, then low with no requests -> rfRegWrite high for exactly 32 consecutive cycles, rfWReg=0..31, rfData=0; readies low throughout; initDone rises with the write of register 31 and stays high.
- After init, req0Valid=1 with req0Reg=3 and req0Data=30 for one cycle -> req0Ready=1 that cycle; next cycle rfRegWrite=1, rfWReg=3, rfData=30; the cycle after, rfRegWrite=0 with rfWReg still 3.
- Both valid for 8 cycles (req0 regs 1..4 data k*10, req1 regs 17..20 data k*10) -> grants alternate starting req0; rf sees writes 1,17,2,18,3,19,4,20 on 8 consecutive cycles.
- req1 alone with reg 5 data 50, then both valid -> req1 granted first; on the next both-valid cycle req0 is granted, confirming the pointer toggled.
- Assert reset for 1 cycle while both requesters stream -> rfRegWrite=0 on the reset edge, readies low, then a full 32-cycle INIT replay; no pre-reset data is written afterwards.
- req0 reg 0 data 99 -> with RF_ARB_ZERO_DROP_EN: req0Ready=1 and rfRegWrite stays 0. Without the macro: rfRegWrite=1, rfWReg=0, rfData=99.
